// File: rtl/seq_detect_param.sv
// Parametrised Mealy serial-pattern detector.
// Consumes one qualified bit per cycle and raises OUT in the same cycle as
// the last bit of PATTERN (MSB first). Supports overlapping and
// non-overlapping detection selectable every cycle, a synchronous clear,
// and a saturating match counter.
module seq_detect_param #(
  parameter int unsigned          LEN     = 4,
  parameter logic [LEN-1:0]       PATTERN = 4'b1011,
  parameter int unsigned          CNT_W   = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN,
  input  logic             IN_VALID,
  input  logic             OVERLAP,
  input  logic             CLR,
  output logic             OUT,
  output logic [CNT_W-1:0] COUNT
);

  // FILL must hold 0..LEN-1, and $clog2(LEN) bits are enough for that.
  localparam int unsigned        FILL_W   = (LEN > 2) ? $clog2(LEN) : 1;
  localparam logic [FILL_W-1:0]  FILL_MAX = FILL_W'(LEN - 1);
  localparam logic [CNT_W-1:0]   CNT_MAX  = {CNT_W{1'b1}};

  // Last LEN-1 consumed bits, newest at the LSB.
  logic [LEN-2:0]   r_hist;
  // Number of valid bits in r_hist; reaching FILL_MAX means the detector is armed.
  logic [FILL_W-1:0] r_fill;
  logic [CNT_W-1:0]  r_count;

  // Candidate window: history followed by the bit on the wire this cycle.
  // Its low LEN-1 bits are also the next history, which keeps LEN=2 legal.
  logic [LEN-1:0] w_window;
  logic           w_armed;
  logic           w_match;

  // Mealy match term, combinational from the live input and the state.
  assign w_window = {r_hist, IN};
  assign w_armed  = (r_fill == FILL_MAX);
  assign w_match  = IN_VALID & w_armed & (w_window == PATTERN);

  assign OUT   = w_match;
  assign COUNT = r_count;

  // History, fill level and match counter update on each qualified bit.
  // NOTE: non-blocking assignments here so every register samples the
  // pre-edge values of its peers, regardless of statement order.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_hist  <= '0;
      r_fill  <= '0;
      r_count <= '0;
    end else if (CLR) begin
      // A clear wins over everything, including a match seen on OUT this cycle.
      r_hist  <= '0;
      r_fill  <= '0;
      r_count <= '0;
    end else if (IN_VALID) begin
      if (w_match && (r_count != CNT_MAX)) begin
        r_count <= r_count + 1'b1;
      end
      if (w_match && !OVERLAP) begin
        // Non-overlapping: the matched bits are discarded, start over.
        r_hist <= '0;
        r_fill <= '0;
      end else begin
        r_hist <= w_window[LEN-2:0];
        if (!w_armed) begin
          r_fill <= r_fill + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_detect_param.sv
// Bench for seq_detect_param: three parameterisations share one stimulus
// stream. The driver pushes the expected OUT/COUNT for each cycle into a
// per-instance queue; a monitor on the falling edge pops and compares.
module tb_seq_detect_param;

  localparam int NDUT = 3;

  logic clk;
  logic rst;
  logic in_bit;
  logic in_valid;
  logic overlap;
  logic clr;

  logic       out0, out1, out2;
  logic [7:0] count0;
  logic [1:0] count1;
  logic [7:0] count2;

  // Instance 0: defaults (LEN=4, 1011, CNT_W=8).
  seq_detect_param u_dut0 (
    .CLK(clk), .RST(rst), .IN(in_bit), .IN_VALID(in_valid),
    .OVERLAP(overlap), .CLR(clr), .OUT(out0), .COUNT(count0)
  );

  // Instance 1: two-bit counter to exercise saturation.
  seq_detect_param #(.LEN(4), .PATTERN(4'b1011), .CNT_W(2)) u_dut1 (
    .CLK(clk), .RST(rst), .IN(in_bit), .IN_VALID(in_valid),
    .OVERLAP(overlap), .CLR(clr), .OUT(out1), .COUNT(count1)
  );

  // Instance 2: five-bit pattern 11011.
  seq_detect_param #(.LEN(5), .PATTERN(5'b11011), .CNT_W(8)) u_dut2 (
    .CLK(clk), .RST(rst), .IN(in_bit), .IN_VALID(in_valid),
    .OVERLAP(overlap), .CLR(clr), .OUT(out2), .COUNT(count2)
  );

  logic        out_a [NDUT];
  logic [31:0] cnt_a [NDUT];
  assign out_a[0] = out0;
  assign out_a[1] = out1;
  assign out_a[2] = out2;
  assign cnt_a[0] = 32'(count0);
  assign cnt_a[1] = 32'(count1);
  assign cnt_a[2] = 32'(count2);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit out;
    int cnt;
    int cyc;
  } exp_t;

  // Reference configuration for each instance.
  int cfg_len [NDUT] = '{4, 4, 5};
  int cfg_pat [NDUT] = '{32'b1011, 32'b1011, 32'b11011};
  int cfg_max [NDUT] = '{255, 3, 255};

  // Reference state: bits consumed since the last restart, and match count.
  bit   hq   [NDUT][$];
  int   mcnt [NDUT];
  exp_t sb   [NDUT][$];

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  task automatic check(string name, int k, int c, int got, int exp);
    n_cmp++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s dut%0d cycle %0d: got %0d expected %0d", name, k, c, got, exp);
    end
  endtask

  // True when the newest LEN-1 recorded bits followed by b spell the pattern.
  function automatic bit model_match(int k, bit b);
    int n;
    int len;
    int pat;
    len = cfg_len[k];
    pat = cfg_pat[k];
    n   = hq[k].size();
    if (n < len - 1) return 1'b0;
    for (int j = 0; j < len - 1; j++) begin
      if (hq[k][n - (len - 1) + j] != pat[len - 1 - j]) return 1'b0;
    end
    return (b == pat[0]);
  endfunction

  // Apply one cycle of inputs and record what each instance should show.
  task automatic drive(bit b, bit v, bit o, bit c, bit r);
    bit m;
    @(posedge clk);
    #1;
    in_bit   = b;
    in_valid = v;
    overlap  = o;
    clr      = c;
    rst      = r;
    cyc++;
    for (int k = 0; k < NDUT; k++) begin
      if (!r) begin
        hq[k].delete();
        mcnt[k] = 0;
      end
      m = r && v && model_match(k, b);
      sb[k].push_back('{out: m, cnt: mcnt[k], cyc: cyc});
      if (r) begin
        if (c) begin
          hq[k].delete();
          mcnt[k] = 0;
        end else if (v) begin
          if (m && mcnt[k] < cfg_max[k]) mcnt[k]++;
          if (m && !o) begin
            hq[k].delete();
          end else begin
            hq[k].push_back(b);
            while (hq[k].size() > cfg_len[k] - 1) void'(hq[k].pop_front());
          end
        end
      end
    end
  endtask

  task automatic send_bits(string bits, bit o);
    for (int i = 0; i < bits.len(); i++) begin
      drive(bits[i] == "1", 1'b1, o, 1'b0, 1'b1);
    end
  endtask

  task automatic do_clear();
    drive($urandom_range(0, 1), 1'b0, 1'b1, 1'b1, 1'b1);
  endtask

  // Monitor: compare whatever the DUTs present against the queued expectation.
  always @(negedge clk) begin
    for (int k = 0; k < NDUT; k++) begin
      if (sb[k].size() > 0) begin
        exp_t e;
        e = sb[k].pop_front();
        check("out",   k, e.cyc, int'(out_a[k]), int'(e.out));
        check("count", k, e.cyc, int'(cnt_a[k]), e.cnt);
      end
    end
  end

  string gapped;

  initial begin
    rst      = 1'b0;
    in_bit   = 1'b0;
    in_valid = 1'b0;
    overlap  = 1'b1;
    clr      = 1'b0;

    // Reset held for two cycles, then released.
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);

    // Overlapping: matches at index 3 and 6.
    send_bits("1011011", 1'b1);
    do_clear();

    // Non-overlapping: single match at index 3.
    send_bits("1011011", 1'b0);
    do_clear();

    // Two idle cycles with random IN between every valid bit.
    gapped = "1011";
    for (int i = 0; i < gapped.len(); i++) begin
      drive(gapped[i] == "1", 1'b1, 1'b1, 1'b0, 1'b1);
      if (i != gapped.len() - 1) begin
        repeat (2) drive($urandom_range(0, 1), 1'b0, 1'b1, 1'b0, 1'b1);
      end
    end
    do_clear();

    // Long overlapping run: five matches, two-bit counter saturates.
    send_bits("1011011011011011", 1'b1);
    do_clear();

    // Partial 11011 aborted by reset, then a full one afterwards.
    send_bits("1101", 1'b1);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    send_bits("11011", 1'b1);

    // Clear after a partial match: the next bit must not complete it.
    do_clear();
    send_bits("1011", 1'b1);
    send_bits("101", 1'b1);
    do_clear();
    send_bits("1", 1'b1);

    // Clear on the cycle that completes a match: OUT shows it, count does not.
    send_bits("101", 1'b1);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    send_bits("1011", 1'b1);

    // Randomised traffic, including per-cycle OVERLAP, sparse CLR and RST.
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 1),
            $urandom_range(0, 3) != 0,
            $urandom_range(0, 1),
            $urandom_range(0, 63) == 0,
            $urandom_range(0, 127) != 0);
    end

    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    for (int k = 0; k < NDUT; k++) begin
      check("drained", k, cyc, sb[k].size(), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_detect_param.md
Name: seq_detect_param

Overview:
- Parametrised Mealy serial-pattern detector. Generalises the fixed 4-bit 1011 overlapping detector to any pattern length and value.
- Adds a runtime overlap/non-overlap mode, input qualification, synchronous clear and a saturating match counter.
- Sits on a serial bit stream (one bit per qualified cycle) and flags pattern completion in the same cycle as the last bit.

Parameters:
- LEN, 4, pattern length in bits; legal range 2..32.
- PATTERN, 4'b1011 (LEN bits wide), target sequence; MSB is received first, LSB last.
- CNT_W, 8, width of the match counter.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RST  input  1  asynchronous, active-low reset.
- IN  input  1  serial data bit.
- IN_VALID  input  1  qualifies IN; the bit is consumed only when high.
- OVERLAP  input  1  1 = overlapping detection, 0 = non-overlapping; sampled per cycle.
- CLR  input  1  synchronous clear of history, fill and counter.
- OUT  output  1  Mealy match flag, combinational.
- COUNT  output  CNT_W  registered count of matches, saturating.

Behaviour:
- State registers:
  - HIST[LEN-2:0]: last LEN-1 consumed bits, newest at LSB.
  - FILL: 0..LEN-1, number of valid bits held in HIST.
  - COUNT.
- Reset (RST low, asynchronous): HIST=0, FILL=0, COUNT=0. OUT is then 0 because FILL<LEN-1.
- Match term: MATCH = IN_VALID & (FILL==LEN-1) & ({HIST,IN}==PATTERN).
- OUT = MATCH. It is combinational from IN, IN_VALID and state, so it follows IN within the same cycle (zero latency, Mealy).
- Clock edge, CLR=1: HIST=0, FILL=0, COUNT=0. All other inputs are ignored that cycle. OUT may still assert combinationally that cycle, but the match is not counted.
- Clock edge, CLR=0, IN_VALID=0: all state holds.
- Clock edge, CLR=0, IN_VALID=1, and not (MATCH & !OVERLAP):
  - HIST <= {HIST[LEN-3:0],IN}; for LEN=2, HIST <= IN.
  - FILL <= min(FILL+1, LEN-1).
- Clock edge, CLR=0, MATCH=1, OVERLAP=0: HIST <= 0 and FILL <= 0. The matched bits are not reused.
- Clock edge, CLR=0, MATCH=1: COUNT <= COUNT+1, saturating at 2^CNT_W-1 (never wraps).
- Equivalent view as an FSM: FILL tracks the warm-up states (0..LEN-2 = filling, LEN-1 = armed); HIST carries the partial-match context.
- OVERLAP changes take effect on the current cycle's update only; history is never retroactively altered.
- Reset asserted mid-stream aborts any partial match immediately. The first bit after reset release is treated as stream bit 0.
- Width rules: PATTERN is compared as exactly LEN bits. COUNT is unsigned.

Test Plan:
- Default params, OVERLAP=1, IN_VALID=1, bits 1,0,1,1,0,1,1 (index 0..6) -> OUT=1 at index 3 and 6 only; COUNT=2 after index 6.
- Same stream, OVERLAP=0 -> OUT=1 at index 3 only; FILL=0 after index 3; COUNT=1.
- Stream 1,0,1,1 with IN_VALID=0 inserted for 2 cycles between every bit (IN toggling randomly during gaps) -> OUT=1 only on the cycle carrying the final 1; gaps cause no state change.
- CNT_W=2, OVERLAP=1, stream 1011011011011011 -> five matches; COUNT goes 1,2,3,3,3 (saturates at 3).
- LEN=5, PATTERN=5'b11011, stream 1,1,0,1 then RST low for 1 cycle, then 1,1,0,1,1 -> no match before reset; match on the 5th bit after reset; COUNT=1.
- CLR pulse after receiving 1,0,1 with COUNT=1, then bit 1 -> no match (FILL=0); COUNT=0 after CLR.
